// File: rtl/udp_sched_pkg.sv
// Shared definitions for the two-channel UDP transmit scheduler.
//   state_e      : scheduler FSM encoding
//   MAX_LEN_DEF  : largest legal UDP payload in bytes
//   GAP_CYC_DEF  : idle cycles inserted after every packet
//   CH0 / CH1    : channel index constants (also the rr pointer values)
package udp_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_XFER,
    ST_FLUSH,
    ST_GAP
  } state_e;

  localparam int MAX_LEN_DEF = 1472;
  localparam int GAP_CYC_DEF = 12;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/udp_tx_fifo_sched_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req_i      : request vector, bit N = channel N
//   acc_i      : strobe, the channel in acc_ch_i has been served
//   acc_ch_i   : index of the served channel
//   gnt_o      : one-hot combinational grant (0 when no request)
module rr_arb2
  import udp_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       acc_i,
  input  logic       acc_ch_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // On a tie the channel that was not served last wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == CH1) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (acc_i) begin
      last_d = acc_ch_i;
    end
  end

  // Pointer starts at ch1 so ch0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= CH1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/udp_tx_fifo_sched.sv
// Shares one UDP TX engine between two 2048x8 byte FIFOs.
// A channel is granted (round-robin) once its FIFO holds its whole packet;
// FIFO reads are then paced by the engine's byte requests.
//   clk, rst_n                 : clock, synchronous active-low reset
//   chN_len_valid/len/ready    : packet-length descriptor handshake
//   chN_rd_level/rd_en/rd_data : FIFO read port (1-cycle read latency)
//   tx_start_en, tx_byte_num   : packet start pulse and held byte count
//   tx_req, tx_data, tx_done   : engine byte request, returned byte, finish
//   grant, busy, err           : active channel, non-idle flag, sticky error
module udp_tx_fifo_sched
  import udp_sched_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 16,
  parameter int LVL_W   = 12,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch0_len_valid,
  input  logic [LEN_W-1:0]  ch0_len,
  output logic              ch0_len_ready,
  input  logic [LVL_W-1:0]  ch0_rd_level,
  output logic              ch0_rd_en,
  input  logic [DATA_W-1:0] ch0_rd_data,
  input  logic              ch1_len_valid,
  input  logic [LEN_W-1:0]  ch1_len,
  output logic              ch1_len_ready,
  input  logic [LVL_W-1:0]  ch1_rd_level,
  output logic              ch1_rd_en,
  input  logic [DATA_W-1:0] ch1_rd_data,
  output logic              tx_start_en,
  output logic [LEN_W-1:0]  tx_byte_num,
  input  logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err
);

  localparam int CMP_W = (LVL_W > LEN_W) ? LVL_W : LEN_W;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

  state_e             state_q;
  logic [1:0]         grant_q;
  logic               tx_start_en_q;
  logic [LEN_W-1:0]   tx_byte_num_q;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   rem_d;
  logic [GAP_W-1:0]   gap_q;
  logic               rdy0_q;
  logic               rdy1_q;
  logic               err_q;
  logic               rd_vld_q;

  logic [CMP_W-1:0]   len0_x, len1_x, lvl0_x, lvl1_x;
  logic               legal0, legal1;
  logic               elig0, elig1;
  logic               bad0, bad1;
  logic               rd_any;
  logic               acc;
  logic [1:0]         arb_gnt;

  assign len0_x = CMP_W'(ch0_len);
  assign len1_x = CMP_W'(ch1_len);
  assign lvl0_x = CMP_W'(ch0_rd_level);
  assign lvl1_x = CMP_W'(ch1_rd_level);

  assign legal0 = (ch0_len != '0) && (ch0_len <= MAX_LEN_L);
  assign legal1 = (ch1_len != '0) && (ch1_len <= MAX_LEN_L);

  // A descriptor whose ready pulse is on the wire is being consumed this
  // cycle and must not be acted on a second time.
  assign elig0 = ch0_len_valid && !rdy0_q && legal0 && (lvl0_x >= len0_x);
  assign elig1 = ch1_len_valid && !rdy1_q && legal1 && (lvl1_x >= len1_x);
  assign bad0  = ch0_len_valid && !rdy0_q && !legal0;
  assign bad1  = ch1_len_valid && !rdy1_q && !legal1;

  // FLUSH drains the rest of an aborted packet so the FIFO stays aligned.
  assign rd_any = (rem_q != '0) &&
                  (((state_q == ST_XFER) && tx_req) || (state_q == ST_FLUSH));
  assign rem_d  = rd_any ? (rem_q - 1'b1) : rem_q;

  assign acc = (state_q == ST_GAP) && (gap_q == GAP_LAST);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({elig1, elig0}),
    .acc_i    (acc),
    .acc_ch_i (grant_q[1]),
    .gnt_o    (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      tx_start_en_q <= 1'b0;
      tx_byte_num_q <= '0;
      rem_q         <= '0;
      gap_q         <= '0;
      rdy0_q        <= 1'b0;
      rdy1_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_vld_q      <= 1'b0;
    end else begin
      tx_start_en_q <= 1'b0;
      rdy0_q        <= 1'b0;
      rdy1_q        <= 1'b0;
      // Only bytes fetched on engine request are forwarded to tx_data.
      rd_vld_q      <= (state_q == ST_XFER) && rd_any;
      case (state_q)
        ST_IDLE: begin
          if (bad0 || bad1) begin
            rdy0_q <= bad0;
            rdy1_q <= bad1;
            err_q  <= 1'b1;
          end else if (arb_gnt != 2'b00) begin
            grant_q       <= arb_gnt;
            tx_start_en_q <= 1'b1;
            tx_byte_num_q <= arb_gnt[0] ? ch0_len : ch1_len;
            rem_q         <= arb_gnt[0] ? ch0_len : ch1_len;
            rdy0_q        <= arb_gnt[0];
            rdy1_q        <= arb_gnt[1];
            state_q       <= ST_START;
          end
        end
        ST_START: begin
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          rem_q <= rem_d;
          if (tx_req && (rem_q == '0)) begin
            err_q <= 1'b1;
          end
          if (tx_done) begin
            gap_q <= '0;
            if (rem_d == '0) begin
              state_q <= ST_GAP;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          rem_q <= rem_d;
          if (rem_d == '0) begin
            gap_q   <= '0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch0_rd_en     = rd_any && grant_q[0];
  assign ch1_rd_en     = rd_any && grant_q[1];
  assign ch0_len_ready = rdy0_q;
  assign ch1_len_ready = rdy1_q;
  assign tx_start_en   = tx_start_en_q;
  assign tx_byte_num   = tx_byte_num_q;
  assign tx_data       = rd_vld_q ? (grant_q[1] ? ch1_rd_data : ch0_rd_data)
                                  : '0;
  assign grant         = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_udp_tx_fifo_sched.sv
module tb_udp_tx_fifo_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch0_len_valid = 1'b0, ch1_len_valid = 1'b0;
  logic [15:0] ch0_len = '0, ch1_len = '0;
  logic        ch0_len_ready, ch1_len_ready;
  logic [11:0] ch0_rd_level = '0, ch1_rd_level = '0;
  logic        ch0_rd_en, ch1_rd_en;
  logic [7:0]  ch0_rd_data = '0, ch1_rd_data = '0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req = 1'b0, tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic [1:0]  grant;
  logic        busy, err;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt0 = 0, cnt1 = 0, n_start = 0;

  always #5 clk = ~clk;

  udp_tx_fifo_sched dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_len_valid(ch0_len_valid), .ch0_len(ch0_len), .ch0_len_ready(ch0_len_ready),
    .ch0_rd_level(ch0_rd_level), .ch0_rd_en(ch0_rd_en), .ch0_rd_data(ch0_rd_data),
    .ch1_len_valid(ch1_len_valid), .ch1_len(ch1_len), .ch1_len_ready(ch1_len_ready),
    .ch1_rd_level(ch1_rd_level), .ch1_rd_en(ch1_rd_en), .ch1_rd_data(ch1_rd_data),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req),
    .tx_data(tx_data), .tx_done(tx_done), .grant(grant), .busy(busy), .err(err)
  );

  // FIFO content: byte n of channel ch
  function automatic logic [7:0] pat(input int ch, input int n);
    logic [7:0] b;
    b = n[7:0];
    return (ch == 0) ? (b ^ 8'h5A) : (b + 8'h80);
  endfunction

  // FIFO read ports with 1-cycle latency, plus event counters
  always @(posedge clk) begin
    if (ch0_rd_en) begin ch0_rd_data <= pat(0, cnt0); cnt0 <= cnt0 + 1; end
    if (ch1_rd_en) begin ch1_rd_data <= pat(1, cnt1); cnt1 <= cnt1 + 1; end
    if (tx_start_en) n_start <= n_start + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    drv(); drv();
    smp();
    check({tag, " busy"},  32'(busy), 0);
    check({tag, " grant"}, 32'(grant), 0);
    check({tag, " err"},   32'(err), 0);
    check({tag, " outs"},  32'({tx_start_en, ch0_rd_en, ch1_rd_en, ch0_len_ready,
                                 ch1_len_ready, tx_byte_num, tx_data}), 0);
    drv();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      smp();
      if (tx_start_en) begin ok = 1'b1; break; end
      drv();
    end
  endtask

  // Serve one packet: len requests, then tx_done; returns channel and GAP length.
  task automatic run_pkt(input string tag, input int maxc, input int len, input bit keep,
                         output int ch, output int gap, output logic [1:0] g);
    bit ok;
    int base, bad, gbad;
    wait_start(maxc, ok);
    check({tag, " start"}, 32'(ok), 1);
    g  = grant;
    ch = grant[1] ? 1 : 0;
    check({tag, " byte_num"}, 32'(tx_byte_num), 32'(len));
    base = (ch == 1) ? cnt1 : cnt0;
    drv();
    if (!keep) begin ch0_len_valid = 1'b0; ch1_len_valid = 1'b0; end
    tx_req = 1'b1;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      smp();
      if (i > 0 && tx_data !== pat(ch, base + i - 1)) bad++;
      drv();
    end
    tx_req = 1'b0;
    smp();
    if (tx_data !== pat(ch, base + len - 1)) bad++;
    check({tag, " data"}, 32'(bad), 0);
    check({tag, " rd_cnt"}, 32'(((ch == 1) ? cnt1 : cnt0) - base), 32'(len));
    drv();
    tx_done = 1'b1;
    drv();
    tx_done = 1'b0;
    gap = 0;
    gbad = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!busy) break;
      if (grant !== g) gbad++;
      gap++;
      drv();
    end
    check({tag, " gap_grant"}, 32'(gbad), 0);
  endtask

  initial begin
    int ch, gap, n, nz, s0, c0, c1;
    logic [1:0] g;
    logic [1:0] exp_g [4];
    bit ok;

    apply_reset("rst0");

    // ch0 len=64, FIFO already full enough
    c1 = cnt1;
    ch0_len = 16'd64; ch0_rd_level = 12'd64; ch0_len_valid = 1'b1;
    run_pkt("t1", 5, 64, 1'b0, ch, gap, g);
    check("t1 grant", 32'(g), 1);
    check("t1 gap", 32'(gap), 12);
    check("t1 idle_grant", 32'(grant), 0);
    check("t1 err", 32'(err), 0);
    check("t1 ch1_rd", 32'(cnt1 - c1), 0);
    check("t1 starts", 32'(n_start), 1);
    check("t1 byte_num_hold", 32'(tx_byte_num), 64);

    // ch0 len=100 waits for the FIFO level to reach 100
    drv();
    ch0_len = 16'd100; ch0_rd_level = 12'd99; ch0_len_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (tx_start_en || busy) n++;
      drv();
    end
    check("t2 stall", 32'(n), 0);
    ch0_rd_level = 12'd100;
    smp();
    check("t2 no_early", 32'(tx_start_en), 0);
    drv();
    run_pkt("t2", 1, 100, 1'b0, ch, gap, g);
    check("t2 grant", 32'(g), 1);
    check("t2 gap", 32'(gap), 12);
    check("t2 err", 32'(err), 0);

    // both eligible, fresh pointer: ch0, ch1, ch0, ch1
    apply_reset("rst1");
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    ch0_len = 16'd10; ch1_len = 16'd10;
    ch0_rd_level = 12'd100; ch1_rd_level = 12'd100;
    ch0_len_valid = 1'b1; ch1_len_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_pkt("t3", 5, 10, 1'b1, ch, gap, g);
      check("t3 rr_grant", 32'(g), 32'(exp_g[k]));
      check("t3 gap", 32'(gap), 12);
    end
    ch0_len_valid = 1'b0; ch1_len_valid = 1'b0;
    check("t3 err", 32'(err), 0);
    drv();

    // illegal descriptors on ch1
    s0 = n_start; c1 = cnt1;
    ch1_len = 16'd0; ch1_rd_level = 12'd0; ch1_len_valid = 1'b1;
    drv(); smp();
    check("t4a ready", 32'(ch1_len_ready), 1);
    check("t4a err", 32'(err), 1);
    drv(); ch1_len_valid = 1'b0; smp();
    check("t4a ready_pulse", 32'(ch1_len_ready), 0);
    drv();
    ch1_len = 16'd2000; ch1_len_valid = 1'b1;
    drv(); smp();
    check("t4b ready", 32'(ch1_len_ready), 1);
    drv(); ch1_len_valid = 1'b0; smp();
    check("t4b ready_pulse", 32'(ch1_len_ready), 0);
    check("t4 err", 32'(err), 1);
    check("t4 busy", 32'(busy), 0);
    check("t4 rd", 32'(cnt1 - c1), 0);
    check("t4 starts", 32'(n_start - s0), 0);

    // early tx_done after 20 of 32 bytes -> FLUSH drains the remaining 12
    drv();
    ch0_len = 16'd32; ch0_rd_level = 12'd32; ch0_len_valid = 1'b1;
    wait_start(5, ok);
    check("t5 start", 32'(ok), 1);
    c0 = cnt0;
    drv();
    ch0_len_valid = 1'b0; tx_req = 1'b1;
    repeat (20) drv();
    tx_req = 1'b0; tx_done = 1'b1;
    drv();
    tx_done = 1'b0;
    n = 0; nz = 0;
    for (int i = 0; i < 100; i++) begin
      smp();
      if (!busy) break;
      if (tx_data !== 8'h00) nz++;
      n++;
      drv();
    end
    check("t5 rd_total", 32'(cnt0 - c0), 32);
    check("t5 flush_gap_cyc", 32'(n), 24);
    check("t5 flush_data", 32'(nz), 0);
    check("t5 err", 32'(err), 1);
    check("t5 grant", 32'(grant), 0);

    // reset pulse in mid-XFER
    drv();
    ch0_len = 16'd16; ch0_rd_level = 12'd16; ch0_len_valid = 1'b1;
    wait_start(5, ok);
    check("t6 start", 32'(ok), 1);
    drv();
    ch0_len_valid = 1'b0; tx_req = 1'b1;
    repeat (5) drv();
    rst_n = 1'b0;
    drv();
    rst_n = 1'b1;
    smp();
    check("t6 busy", 32'(busy), 0);
    check("t6 grant", 32'(grant), 0);
    check("t6 rd_en", 32'({ch0_rd_en, ch1_rd_en}), 0);
    check("t6 err", 32'(err), 0);
    drv();
    tx_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
